// File: rtl/lstm_mac_scheduler_pkg.sv
// lstm_mac_scheduler_pkg: state encoding, gate indices and address widths shared by the scheduler slice
package lstm_mac_scheduler_pkg;
    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;
    localparam int NUM_GATES = 4;
    localparam int GATE_I = 0;
    localparam int GATE_F = 1;
    localparam int GATE_G = 2;
    localparam int GATE_O = 3;
    localparam int WT_ADDR_WIDTH = 13;
    localparam int RES_ADDR_WIDTH = 10;
endpackage

// File: rtl/lstm_mac_scheduler_if.sv
// lstm_mac_scheduler_if: requester, MAC and result-buffer signals; slave is the scheduler side
interface lstm_mac_scheduler_if #(
    parameter int OUTPUT_WIDTH = 32,
    parameter int WT_ADDR_WIDTH = lstm_mac_scheduler_pkg::WT_ADDR_WIDTH,
    parameter int RES_ADDR_WIDTH = lstm_mac_scheduler_pkg::RES_ADDR_WIDTH
);
    logic [1:0] req;
    logic [1:0] gnt;
    logic [1:0] job_done;
    logic busy;
    logic mac_start;
    logic [WT_ADDR_WIDTH-1:0] wt_base;
    logic mac_valid;
    logic signed [OUTPUT_WIDTH-1:0] mac_out_element;
    logic mac_done;
    logic res_we;
    logic [RES_ADDR_WIDTH-1:0] res_addr;
    logic signed [OUTPUT_WIDTH-1:0] res_data;
    logic err;
    modport master (
        output req, mac_valid, mac_out_element, mac_done,
        input gnt, job_done, busy, mac_start, wt_base, res_we, res_addr, res_data, err
    );
    modport slave (
        input req, mac_valid, mac_out_element, mac_done,
        output gnt, job_done, busy, mac_start, wt_base, res_we, res_addr, res_data, err
    );
endinterface

// File: rtl/lstm_mac_scheduler_rr_arbiter2.sv
// rr_arbiter2: two-way round-robin arbiter; ptr picks the winner only when both request
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] grant
);
    assign grant = (req[0] && !(req[1] && ptr)) ? 2'b01 : req[1] ? 2'b10 : 2'b00;
endmodule

// File: rtl/lstm_mac_scheduler.sv
// lstm_mac_scheduler: grants forward/backward jobs round-robin and sequences the shared MAC
// through NUM_GATES passes per job, writing each element to the result buffer
module lstm_mac_scheduler
    import lstm_mac_scheduler_pkg::*;
#(
    parameter int OUTPUT_WIDTH = 32,
    parameter int COLS_B = 100,
    parameter int NUM_GATES = lstm_mac_scheduler_pkg::NUM_GATES,
    parameter int GATE_WT_SIZE = 600,
    parameter int WT_ADDR_WIDTH = lstm_mac_scheduler_pkg::WT_ADDR_WIDTH,
    parameter int RES_ADDR_WIDTH = lstm_mac_scheduler_pkg::RES_ADDR_WIDTH
) (
    input logic clk,
    input logic rst,
    lstm_mac_scheduler_if.slave bus
);
    localparam int GW = NUM_GATES > 1 ? $clog2(NUM_GATES) : 1;
    localparam int CW = $clog2(COLS_B + 1);
    localparam logic [GW-1:0] GATE_LAST = GW'(NUM_GATES - 1);
    localparam logic [CW-1:0] COLS_MAX = CW'(COLS_B);

    state_t state, state_d;
    logic [1:0] grant, gnt, gnt_d, job_done, job_done_d;
    logic busy, busy_d, mac_start, mac_start_d, res_we, res_we_d, err, err_d, rr_ptr, rr_ptr_d;
    logic [WT_ADDR_WIDTH-1:0] wt_base, wt_base_d;
    logic [RES_ADDR_WIDTH-1:0] res_addr, res_addr_d;
    logic signed [OUTPUT_WIDTH-1:0] res_data, res_data_d;
    logic [GW-1:0] gate, gate_d;
    logic [CW-1:0] col, col_d;

    function automatic logic [WT_ADDR_WIDTH-1:0] wt_of(input logic dir, input logic [GW-1:0] g);
        return WT_ADDR_WIDTH'((int'(dir) * NUM_GATES + int'(g)) * GATE_WT_SIZE);
    endfunction

    function automatic logic [RES_ADDR_WIDTH-1:0] res_of(input logic dir, input logic [GW-1:0] g,
                                                         input logic [CW-1:0] c);
        return RES_ADDR_WIDTH'((int'(dir) * NUM_GATES + int'(g)) * COLS_B + int'(c));
    endfunction

    rr_arbiter2 u_arb (.req(bus.req), .ptr(rr_ptr), .grant(grant));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            gnt <= '0;
            job_done <= '0;
            busy <= 1'b0;
            mac_start <= 1'b0;
            wt_base <= '0;
            res_we <= 1'b0;
            res_addr <= '0;
            res_data <= '0;
            err <= 1'b0;
            gate <= '0;
            col <= '0;
            rr_ptr <= 1'b0;
        end else begin
            state <= state_d;
            gnt <= gnt_d;
            job_done <= job_done_d;
            busy <= busy_d;
            mac_start <= mac_start_d;
            wt_base <= wt_base_d;
            res_we <= res_we_d;
            res_addr <= res_addr_d;
            res_data <= res_data_d;
            err <= err_d;
            gate <= gate_d;
            col <= col_d;
            rr_ptr <= rr_ptr_d;
        end
    end

    always_comb begin
        state_d = (state == IDLE && grant != 2'b00) ? RUN :
                  (state == RUN && bus.mac_done && gate == GATE_LAST) ? FINISH :
                  (state == FINISH) ? IDLE : state;
    end

    // element write is resolved before mac_done so a same-cycle last element lands in its pass
    always_comb begin
        gnt_d = gnt;
        job_done_d = 2'b00;
        busy_d = state_d != IDLE;
        mac_start_d = 1'b0;
        wt_base_d = wt_base;
        res_we_d = 1'b0;
        res_addr_d = res_addr;
        res_data_d = res_data;
        err_d = err;
        gate_d = gate;
        col_d = col;
        rr_ptr_d = rr_ptr;
        if (state == IDLE && grant != 2'b00) begin
            gnt_d = grant;
            gate_d = GW'(GATE_I);
            col_d = '0;
            mac_start_d = 1'b1;
            wt_base_d = wt_of(grant[1], GW'(GATE_I));
        end
        if (bus.mac_valid) begin
            if (state != RUN || col == COLS_MAX) begin
                err_d = 1'b1;
            end else begin
                res_we_d = 1'b1;
                res_data_d = bus.mac_out_element;
                res_addr_d = res_of(gnt[1], gate, col);
                col_d = col + 1'b1;
            end
        end
        if (state == RUN && bus.mac_done) begin
            err_d = err_d | (col_d != COLS_MAX);
            if (gate != GATE_LAST) begin
                gate_d = gate + 1'b1;
                col_d = '0;
                wt_base_d = wt_of(gnt[1], gate + 1'b1);
                mac_start_d = 1'b1;
            end
        end
        if (state == FINISH) begin
            job_done_d = gnt;
            gnt_d = 2'b00;
            rr_ptr_d = ~gnt[1];
        end
    end

    assign bus.gnt = gnt;
    assign bus.job_done = job_done;
    assign bus.busy = busy;
    assign bus.mac_start = mac_start;
    assign bus.wt_base = wt_base;
    assign bus.res_we = res_we;
    assign bus.res_addr = res_addr;
    assign bus.res_data = res_data;
    assign bus.err = err;
endmodule

// File: tb/tb_lstm_mac_scheduler.sv
// tb_lstm_mac_scheduler: random MAC/requester stimulus checked against a job-level model of
// grants, pass bases, result addresses, completion pulses and the sticky error flag
module tb_lstm_mac_scheduler;
    localparam int CB = 100;
    localparam int NG = 4;
    localparam int GWS = 600;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_vec = 0;
    int n_bad = 0;
    bit rr_m = 1'b0;
    bit err_m = 1'b0;

    always #5 clk = ~clk;

    lstm_mac_scheduler_if sif ();
    lstm_mac_scheduler dut (.clk(clk), .rst(rst), .bus(sif));

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // asserted mid-phase so the outputs must clear without waiting for an edge
    task automatic do_reset(input string tag);
        sif.req = 2'b00;
        sif.mac_valid = 1'b0;
        sif.mac_done = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk({tag, "_ctl"}, {sif.gnt, sif.job_done, sif.busy, sif.mac_start, sif.res_we, sif.err}, 0);
        chk({tag, "_data"}, {sif.wt_base, sif.res_addr, sif.res_data}, 0);
        @(negedge clk);
        rst = 1'b0;
        rr_m = 1'b0;
        err_m = 1'b0;
    endtask

    task automatic run_job(input logic [1:0] r, input int nval, input bit same, input bit drop,
                           input bit keep, input int abort_gate);
        bit dir;
        int lat;
        logic signed [31:0] d;
        dir = (r == 2'b11) ? rr_m : r[1];
        sif.req = r;
        lat = 0;
        do begin
            step();
            lat++;
        end while (!sif.mac_start && lat < 20);
        chk("start_lat", lat, 1);
        chk("jd_idle", sif.job_done, 0);
        chk("gnt", sif.gnt, dir ? 2'b10 : 2'b01);
        chk("busy", sif.busy, 1);
        for (int g = 0; g < NG; g++) begin
            chk("mac_start", sif.mac_start, 1);
            chk("wt_base", sif.wt_base, (int'(dir) * NG + g) * GWS);
            if (drop && g == 1) sif.req = 2'b00;
            for (int c = 0; c < nval; c++) begin
                if ($urandom_range(0, 3) == 0) begin
                    step();
                    chk("gap_we", sif.res_we, 0);
                end
                if (g == abort_gate && c == nval / 2) begin
                    do_reset("abort");
                    repeat (3) begin
                        step();
                        chk("abort_jd", sif.job_done, 0);
                        chk("abort_we", sif.res_we, 0);
                    end
                    return;
                end
                d = $urandom;
                sif.mac_valid = 1'b1;
                sif.mac_out_element = d;
                sif.mac_done = same && c == nval - 1;
                step();
                sif.mac_valid = 1'b0;
                sif.mac_done = 1'b0;
                if (c < CB) begin
                    chk("we", sif.res_we, 1);
                    chk("addr", sif.res_addr, int'(dir) * NG * CB + g * CB + c);
                    chk("data", sif.res_data, d);
                end else begin
                    chk("we_sup", sif.res_we, 0);
                end
            end
            if (!same) begin
                sif.mac_done = 1'b1;
                step();
                sif.mac_done = 1'b0;
            end
            err_m |= nval != CB;
            chk("err", sif.err, err_m);
        end
        chk("fin_jd", sif.job_done, 0);
        chk("fin_busy", sif.busy, 1);
        step();
        chk("job_done", sif.job_done, dir ? 2'b10 : 2'b01);
        chk("gnt_clr", sif.gnt, 0);
        chk("busy_clr", sif.busy, 0);
        rr_m = !dir;
        if (!keep) begin
            sif.req = 2'b00;
            step();
            chk("no_regrant", {sif.busy, sif.mac_start, sif.job_done}, 0);
        end
    endtask

    initial begin
        sif.req = 2'b00;
        sif.mac_valid = 1'b0;
        sif.mac_done = 1'b0;
        sif.mac_out_element = '0;
        @(negedge clk);
        do_reset("reset");
        run_job(2'b01, CB, 1'b0, 1'b0, 1'b0, -1);
        do_reset("reset2");
        run_job(2'b11, CB, 1'b0, 1'b0, 1'b1, -1);
        run_job(2'b11, CB, 1'b0, 1'b0, 1'b1, -1);
        run_job(2'b11, CB, 1'b0, 1'b0, 1'b0, -1);
        run_job(2'b10, CB, 1'b1, 1'b0, 1'b0, -1);
        run_job(2'b01, CB - 1, 1'b0, 1'b0, 1'b0, -1);
        sif.mac_valid = 1'b1;
        step();
        sif.mac_valid = 1'b0;
        chk("idle_valid_we", sif.res_we, 0);
        chk("idle_valid_err", sif.err, 1);
        do_reset("reset3");
        sif.mac_valid = 1'b1;
        step();
        sif.mac_valid = 1'b0;
        chk("idle_err_set", sif.err, 1);
        repeat (3) step();
        chk("err_sticky", sif.err, 1);
        do_reset("reset4");
        run_job(2'b10, CB + 1, 1'b0, 1'b0, 1'b0, -1);
        do_reset("reset5");
        run_job(2'b10, CB, 1'b0, 1'b0, 1'b0, 2);
        run_job(2'b01, CB, 1'b0, 1'b0, 1'b0, -1);
        do_reset("reset6");
        repeat (8) begin
            run_job(2'($urandom_range(1, 3)), CB, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), -1);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule

// File: doc/lstm_mac_scheduler.md
LSTM_MAC_SCHEDULER -- requirements
Module: lstm_mac_scheduler

Interface
REQ-001 Parameters SHALL be (name, default, meaning): OUTPUT_WIDTH 32 MAC result width (Q12.20); COLS_B 100 outputs per gate pass; NUM_GATES 4 gate passes per job (i,f,g,o); GATE_WT_SIZE 600 weight words per gate; WT_ADDR_WIDTH 13; RES_ADDR_WIDTH 10.
REQ-002 clk input 1: clock, all logic on rising edge.
REQ-003 rst input 1: reset, asynchronous, active-high.
REQ-004 req input 2: job requests, bit0 forward direction, bit1 backward direction; level, held until done.
REQ-005 gnt output 2: one-hot grant, high for the whole job.
REQ-006 job_done output 2: one-cycle completion pulse to the granted requester.
REQ-007 busy output 1: high whenever state is not IDLE.
REQ-008 mac_start output 1: one-cycle start pulse to the shared MAC unit.
REQ-009 wt_base output WT_ADDR_WIDTH: weight-memory base offset for the current pass.
REQ-010 mac_valid input 1, mac_out_element input OUTPUT_WIDTH signed, mac_done input 1: MAC element strobe, element data and pass-complete pulse.
REQ-011 res_we output 1, res_addr output RES_ADDR_WIDTH, res_data output OUTPUT_WIDTH: result-buffer write port.
REQ-012 err output 1: sticky protocol-error flag.

Function
REQ-013 FSM states SHALL be IDLE, RUN and FINISH; all outputs SHALL be registered.
REQ-014 IDLE: if req != 0, the block SHALL pick one requester, set gnt, gate=0, col=0, load wt_base, pulse mac_start and go to RUN on the same edge; req-to-mac_start latency is 1 cycle.
REQ-015 Arbitration SHALL be round-robin: with both req bits high, grant the bit indicated by rr_ptr (reset 0 = forward); after each job, rr_ptr SHALL point to the other requester.
REQ-016 A single active req bit SHALL be granted regardless of rr_ptr.
REQ-017 wt_base SHALL equal (dir*NUM_GATES + gate)*GATE_WT_SIZE, where dir is the granted index.
REQ-018 RUN, mac_valid=1: the block SHALL assert res_we=1 next cycle with res_data=mac_out_element and res_addr=dir*NUM_GATES*COLS_B + gate*COLS_B + col, then increment col.
REQ-019 res_we SHALL be a one-cycle pulse per accepted mac_valid.
REQ-020 RUN, mac_done=1 with gate<NUM_GATES-1: the block SHALL increment gate, clear col, update wt_base and pulse mac_start on the same edge.
REQ-021 RUN, mac_done=1 with gate=NUM_GATES-1: the block SHALL go to FINISH.
REQ-022 mac_done in the same cycle as mac_valid SHALL write the element first (col increment), then apply REQ-020/021.
REQ-023 FINISH: the block SHALL pulse job_done for the granted bit, clear gnt, toggle rr_ptr and return to IDLE; the next grant is possible no earlier than 1 cycle later.
REQ-024 Deasserting req mid-job SHALL NOT abort the job; the job completes normally.
REQ-025 err SHALL set and stay high until reset on any of the following: mac_valid outside RUN; mac_valid with col=COLS_B (write suppressed); mac_done with col!=COLS_B (pass still advances).
REQ-026 Arithmetic for addresses SHALL be unsigned, with no wrap within the parameter ranges; data SHALL pass through unmodified.

Reset
REQ-027 On rst the block SHALL immediately set state IDLE; gnt, job_done, busy, mac_start, res_we and err to 0; wt_base, res_addr, res_data, gate, col to 0; rr_ptr to 0.
REQ-028 rst mid-job SHALL abandon the job with no job_done pulse and no further writes.

Structure
REQ-029 A shared package SHALL hold the state encoding, NUM_GATES, the gate index constants (I=0, F=1, G=2, O=3) and the address-width constants.
REQ-030 A sub-module rr_arbiter2 (2-way round-robin, req/ptr in, one-hot grant out) SHALL hold the arbitration logic; the rest SHALL be a single FSM.

Verification
REQ-031 Scenario 1: req=01 with a MAC model giving 100 valids per pass -> 4 passes, wt_base 0/600/1200/1800, 400 writes at addresses 0..399, one job_done=01, err=0.
REQ-032 Scenario 2: req=11 from reset -> forward served first (addresses 0..399), then backward (wt_base 2400.., addresses 400..799), then forward again if req stays high.
REQ-033 Scenario 3: mac_valid and mac_done in the same cycle on the 100th element -> address gate*100+99 written and the next pass starts, err=0.
REQ-034 Scenario 4: MAC model gives 99 valids before mac_done -> err=1 sticky and the job still completes; an extra valid in IDLE -> err=1 and res_we=0.
REQ-035 Scenario 5: rst asserted during gate 2 of a backward job -> all outputs 0 at once, no job_done; after release, req=01 is granted forward.
